// File: rtl/reg_ctx_sequencer_if.sv
// Bus bundle for reg_ctx_sequencer.
//   master : the sequencer side (drives Busy/Done/Aborted, register-file port 3, memory request)
//   slave  : the environment side (trap logic requests, register file read-back, memory response)
interface reg_ctx_sequencer_if;
  logic        Save_Req;
  logic        Restore_Req;
  logic        Abort;
  logic [31:0] Base_Addr;
  logic        Busy;
  logic        Done;
  logic        Aborted;
  logic [5:0]  Rf_Sel;
  logic        Rf_Write;
  logic [31:0] Rf_Write_Data;
  logic [31:0] Rf_Read_Data;
  logic        Mem_Req;
  logic        Mem_Write;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_Wdata;
  logic        Mem_Ack;
  logic [31:0] Mem_Rdata;

  modport master (
    input  Save_Req, Restore_Req, Abort, Base_Addr, Rf_Read_Data, Mem_Ack, Mem_Rdata,
    output Busy, Done, Aborted, Rf_Sel, Rf_Write, Rf_Write_Data,
           Mem_Req, Mem_Write, Mem_Addr, Mem_Wdata
  );

  modport slave (
    output Save_Req, Restore_Req, Abort, Base_Addr, Rf_Read_Data, Mem_Ack, Mem_Rdata,
    input  Busy, Done, Aborted, Rf_Sel, Rf_Write, Rf_Write_Data,
           Mem_Req, Mem_Write, Mem_Addr, Mem_Wdata
  );
endinterface

// File: rtl/reg_ctx_sequencer.sv
// Context save/restore sequencer for the 64x32 register file.
// Walks registers FIRST_REG..LAST_REG through register-file port 3 and moves
// each word to (save) or from (restore) a memory buffer at a latched base.
// Ports:
//   Slow_Clock : clock, all state on posedge
//   Reset_n    : asynchronous active-low reset
//   bus        : request/status, register-file port 3 and memory port (master side)
// All outputs are decoded from registered state only, so they drop to 0 the
// moment reset is asserted.
module reg_ctx_sequencer #(
  parameter int FIRST_REG   = 1,
  parameter int LAST_REG    = 63,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                 Slow_Clock,
  input  logic                 Reset_n,
  reg_ctx_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, SAVE_RD, SAVE_MEM, RST_MEM, RST_WR, FINISH
  } state_t;

  localparam logic [5:0] FIRST = 6'(FIRST_REG);
  localparam logic [5:0] LAST  = 6'(LAST_REG);

  state_t      state, state_n;
  logic [5:0]  idx, idx_n;
  logic [31:0] base, base_n;
  logic [31:0] data, data_n;
  logic        ab, ab_n;

  logic        abort_now;
  logic        last;
  logic [31:0] addr;

  assign abort_now = ab | bus.Abort;
  assign last      = (idx == LAST);
  // Wraps modulo 2^32 by construction.
  assign addr      = base + (({26'd0, idx} - 32'(FIRST_REG)) * 32'(ADDR_STRIDE));

  always_ff @(posedge Slow_Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      idx   <= FIRST;
      base  <= '0;
      data  <= '0;
      ab    <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      base  <= base_n;
      data  <= data_n;
      ab    <= ab_n;
    end
  end

  always_comb begin
    state_n           = state;
    idx_n             = idx;
    base_n            = base;
    data_n            = data;
    ab_n              = ab;
    bus.Busy          = (state != IDLE);
    bus.Done          = 1'b0;
    bus.Aborted       = 1'b0;
    bus.Rf_Sel        = '0;
    bus.Rf_Write      = 1'b0;
    bus.Rf_Write_Data = '0;
    bus.Mem_Req       = 1'b0;
    bus.Mem_Write     = 1'b0;
    bus.Mem_Addr      = '0;
    bus.Mem_Wdata     = '0;

    case (state)
      IDLE: begin
        ab_n  = 1'b0;
        idx_n = FIRST;
        if (bus.Save_Req) begin
          base_n  = bus.Base_Addr;
          state_n = SAVE_RD;
        end else if (bus.Restore_Req) begin
          base_n  = bus.Base_Addr;
          state_n = RST_MEM;
        end
      end

      SAVE_RD: begin
        bus.Rf_Sel = idx;
        data_n     = bus.Rf_Read_Data;
        ab_n       = abort_now;
        state_n    = abort_now ? FINISH : SAVE_MEM;
      end

      // Request fields are driven from registers only, so they hold steady
      // until the Ack cycle.
      SAVE_MEM: begin
        bus.Mem_Req   = 1'b1;
        bus.Mem_Write = 1'b1;
        bus.Mem_Addr  = addr;
        bus.Mem_Wdata = data;
        ab_n          = abort_now;
        if (bus.Mem_Ack) begin
          if (abort_now || last) state_n = FINISH;
          else begin
            idx_n   = idx + 6'd1;
            state_n = SAVE_RD;
          end
        end
      end

      RST_MEM: begin
        bus.Mem_Req  = 1'b1;
        bus.Mem_Addr = addr;
        ab_n         = abort_now;
        if (bus.Mem_Ack) begin
          data_n  = bus.Mem_Rdata;
          // An abort taken here skips the register write entirely.
          state_n = abort_now ? FINISH : RST_WR;
        end
      end

      RST_WR: begin
        bus.Rf_Sel        = idx;
        bus.Rf_Write      = 1'b1;
        bus.Rf_Write_Data = data;
        ab_n              = abort_now;
        if (abort_now || last) state_n = FINISH;
        else begin
          idx_n   = idx + 6'd1;
          state_n = RST_MEM;
        end
      end

      FINISH: begin
        bus.Done    = ~ab;
        bus.Aborted = ab;
        ab_n        = 1'b0;
        idx_n       = FIRST;
        state_n     = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
module tb_reg_ctx_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_ctx_sequencer_if bus();

  reg_ctx_sequencer #(.FIRST_REG(1), .LAST_REG(63), .ADDR_STRIDE(4)) dut (
    .Slow_Clock(clk),
    .Reset_n(rst_n),
    .bus(bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Register file model: combinational port-3 read, write committed on negedge.
  logic [31:0] rf [64];
  assign bus.Rf_Read_Data = rf[bus.Rf_Sel];

  // Memory responder / monitor state
  int unsigned wait_w = 0;
  logic [31:0] rbase = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int rd_cnt, rfw_cnt, rf0_err, done_cnt, ab_cnt, stab_err;
  int unsigned wcnt;
  logic [31:0] lat_addr, lat_wdata;
  logic lat_write;

  initial begin
    bus.Mem_Ack = 1'b0;
    bus.Mem_Rdata = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (bus.Rf_Write) begin
        rf[bus.Rf_Sel] = bus.Rf_Write_Data;
        rfw_cnt++;
        if (bus.Rf_Sel == 6'd0) rf0_err++;
      end
      if (bus.Done) done_cnt++;
      if (bus.Aborted) ab_cnt++;
      if (!rst_n) begin
        bus.Mem_Ack = 1'b0;
        wcnt = 0;
      end else if (bus.Mem_Ack) begin
        bus.Mem_Ack = 1'b0;
        wcnt = 0;
      end else if (bus.Mem_Req) begin
        if (wcnt == 0) begin
          lat_addr = bus.Mem_Addr; lat_wdata = bus.Mem_Wdata; lat_write = bus.Mem_Write;
        end else if (lat_addr !== bus.Mem_Addr || lat_wdata !== bus.Mem_Wdata ||
                     lat_write !== bus.Mem_Write) stab_err++;
        if (wcnt == wait_w) begin
          bus.Mem_Ack = 1'b1;
          bus.Mem_Rdata = 32'hA500_0000 + ((bus.Mem_Addr - rbase) >> 2);
          if (bus.Mem_Write) begin
            wr_addr.push_back(bus.Mem_Addr);
            wr_data.push_back(bus.Mem_Wdata);
          end else rd_cnt++;
        end else wcnt++;
      end
    end
  end

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete();
    rd_cnt = 0; rfw_cnt = 0; rf0_err = 0; done_cnt = 0; ab_cnt = 0; stab_err = 0;
  endtask

  task automatic preload_save();
    for (int k = 0; k < 64; k++) rf[k] = 32'(k) * 32'h0101_0101;
  endtask

  // Leaves the caller at the negedge of the first cycle after the request posedge.
  task automatic start(input logic sv, input logic rs, input logic [31:0] base);
    @(negedge clk);
    bus.Save_Req = sv; bus.Restore_Req = rs; bus.Base_Addr = base;
    @(negedge clk);
    bus.Save_Req = 1'b0; bus.Restore_Req = 1'b0; bus.Base_Addr = 32'hDEAD_BEEF;
  endtask

  // Counts busy cycles; optional abort when a restore read of abort_addr is pending,
  // optional Restore_Req pulse at busy cycle pulse_at.
  task automatic run_seq(input bit ab_en, input logic [31:0] abort_addr, input int pulse_at,
                         output int busy, output int done_at);
    bit fired = 0;
    busy = 0; done_at = 0;
    while (bus.Busy && busy < 2000) begin
      busy++;
      if (bus.Done || bus.Aborted) done_at = busy;
      bus.Restore_Req = (busy == pulse_at);
      if (ab_en && !fired && bus.Mem_Req && !bus.Mem_Write && bus.Mem_Addr == abort_addr) begin
        bus.Abort = 1'b1; fired = 1;
      end else bus.Abort = 1'b0;
      @(negedge clk);
    end
    bus.Abort = 1'b0; bus.Restore_Req = 1'b0;
    total_cnt++;
    if (busy >= 2000) $display("FAIL timeout: busy still high after %0d cycles", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Aborted !== 1'b0) $display("FAIL reset_status: busy=%b done=%b aborted=%b want 000", bus.Busy, bus.Done, bus.Aborted);
    else pass_cnt++;
    total_cnt++;
    if (bus.Rf_Sel !== 6'd0 || bus.Rf_Write !== 1'b0 || bus.Rf_Write_Data !== 32'd0) $display("FAIL reset_rf: sel=%0d wr=%b wd=%h want 0", bus.Rf_Sel, bus.Rf_Write, bus.Rf_Write_Data);
    else pass_cnt++;
    total_cnt++;
    if (bus.Mem_Req !== 1'b0 || bus.Mem_Write !== 1'b0 || bus.Mem_Addr !== 32'd0 || bus.Mem_Wdata !== 32'd0) $display("FAIL reset_mem: req=%b wr=%b addr=%h wd=%h want 0", bus.Mem_Req, bus.Mem_Write, bus.Mem_Addr, bus.Mem_Wdata);
    else pass_cnt++;
  endtask

  task automatic test_save();
    int busy, done_at, aerr, derr;
    preload_save(); clear_mon(); wait_w = 0;
    start(1, 0, 32'h0000_1000);
    total_cnt++;
    if (bus.Busy !== 1'b1) $display("FAIL save_start_busy: got %b want 1", bus.Busy);
    else pass_cnt++;
    run_seq(0, 0, -1, busy, done_at);
    total_cnt++;
    if (busy != 127 || done_at != 127) $display("FAIL save_cycles: busy=%0d done_at=%0d want 127/127", busy, done_at);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr.size() != 63) $display("FAIL save_count: got %0d want 63", wr_addr.size());
    else pass_cnt++;
    aerr = 0; derr = 0;
    for (int i = 0; i < 63 && i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== 32'h1000 + 32'(i) * 4) aerr++;
      if (wr_data[i] !== 32'(i + 1) * 32'h0101_0101) derr++;
    end
    total_cnt++;
    if (aerr != 0 || derr != 0) $display("FAIL save_words: addr_errs=%0d data_errs=%0d want 0/0", aerr, derr);
    else pass_cnt++;
    total_cnt++;
    if (rfw_cnt != 0 || done_cnt != 1 || ab_cnt != 0) $display("FAIL save_flags: rf_writes=%0d done=%0d aborted=%0d want 0/1/0", rfw_cnt, done_cnt, ab_cnt);
    else pass_cnt++;
  endtask

  task automatic test_restore();
    int busy, done_at, errs;
    for (int k = 0; k < 64; k++) rf[k] = 32'hDEAD_0000 + 32'(k);
    rf[0] = 32'h1234_5678;
    clear_mon(); wait_w = 2; rbase = 32'h0000_2000;
    start(0, 1, 32'h0000_2000);
    run_seq(0, 0, -1, busy, done_at);
    total_cnt++;
    if (busy != 253 || done_at != 253) $display("FAIL restore_cycles: busy=%0d done_at=%0d want 253/253", busy, done_at);
    else pass_cnt++;
    errs = 0;
    for (int k = 1; k < 64; k++) if (rf[k] !== 32'hA500_0000 + 32'(k - 1)) errs++;
    total_cnt++;
    if (errs != 0) $display("FAIL restore_regs: %0d wrong registers, rf[1]=%h want a5000000", errs, rf[1]);
    else pass_cnt++;
    total_cnt++;
    if (rf[0] !== 32'h1234_5678) $display("FAIL restore_reg0: got %h want 12345678", rf[0]);
    else pass_cnt++;
    total_cnt++;
    if (rd_cnt != 63 || wr_addr.size() != 0 || rfw_cnt != 63 || rf0_err != 0) $display("FAIL restore_txn: reads=%0d writes=%0d rf_writes=%0d rf0=%0d want 63/0/63/0", rd_cnt, wr_addr.size(), rfw_cnt, rf0_err);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt != 1 || ab_cnt != 0 || stab_err != 0) $display("FAIL restore_flags: done=%0d aborted=%0d unstable=%0d want 1/0/0", done_cnt, ab_cnt, stab_err);
    else pass_cnt++;
  endtask

  task automatic test_both_req();
    int busy, done_at;
    preload_save(); clear_mon(); wait_w = 0;
    start(1, 1, 32'h0000_1000);
    run_seq(0, 0, 20, busy, done_at);
    @(negedge clk);
    total_cnt++;
    if (wr_addr.size() != 63 || rd_cnt != 0 || busy != 127) $display("FAIL both_req: writes=%0d reads=%0d busy=%0d want 63/0/127", wr_addr.size(), rd_cnt, busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.Busy !== 1'b0 || rfw_cnt != 0) $display("FAIL busy_req_ignored: busy=%b rf_writes=%0d want 0/0", bus.Busy, rfw_cnt);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int busy, done_at;
    for (int k = 0; k < 64; k++) rf[k] = 32'h5555_0000 + 32'(k);
    clear_mon(); wait_w = 2; rbase = 32'h0000_3000;
    start(0, 1, 32'h0000_3000);
    run_seq(1, 32'h0000_3000 + 9 * 4, -1, busy, done_at);
    total_cnt++;
    if (busy != 40 || done_at != 40) $display("FAIL abort_cycles: busy=%0d pulse_at=%0d want 40/40", busy, done_at);
    else pass_cnt++;
    total_cnt++;
    if (rf[10] !== 32'h5555_000A || rf[9] !== 32'hA500_0008) $display("FAIL abort_regs: rf10=%h rf9=%h want 5555000a/a5000008", rf[10], rf[9]);
    else pass_cnt++;
    total_cnt++;
    if (rd_cnt != 10 || rfw_cnt != 9) $display("FAIL abort_txn: reads=%0d rf_writes=%0d want 10/9", rd_cnt, rfw_cnt);
    else pass_cnt++;
    total_cnt++;
    if (ab_cnt != 1 || done_cnt != 0) $display("FAIL abort_flags: aborted=%0d done=%0d want 1/0", ab_cnt, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int busy, done_at, n;
    preload_save(); clear_mon(); wait_w = 0;
    start(1, 0, 32'h0000_4000);
    n = 0;
    while (bus.Rf_Sel != 6'd30 && n < 500) begin n++; @(negedge clk); end
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.Busy !== 1'b0 || bus.Mem_Req !== 1'b0 || bus.Mem_Addr !== 32'd0 || bus.Rf_Sel !== 6'd0 ||
        bus.Done !== 1'b0 || bus.Aborted !== 1'b0 || n >= 500)
      $display("FAIL reset_mid_outputs: busy=%b req=%b addr=%h sel=%0d n=%0d want all 0", bus.Busy, bus.Mem_Req, bus.Mem_Addr, bus.Rf_Sel, n);
    else pass_cnt++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    total_cnt++;
    if (wr_addr.size() != 29 || done_cnt != 0 || ab_cnt != 0) $display("FAIL reset_mid_partial: writes=%0d done=%0d aborted=%0d want 29/0/0", wr_addr.size(), done_cnt, ab_cnt);
    else pass_cnt++;
    clear_mon();
    start(1, 0, 32'h0000_5000);
    run_seq(0, 0, -1, busy, done_at);
    total_cnt++;
    if (wr_addr.size() != 63 || wr_addr[0] !== 32'h5000 || wr_data[0] !== 32'h0101_0101 || wr_addr[62] !== 32'h50F8)
      $display("FAIL reset_restart: writes=%0d first=%h/%h want 63 5000/01010101", wr_addr.size(), wr_addr[0], wr_data[0]);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt != 1 || busy != 127) $display("FAIL reset_restart_done: done=%0d busy=%0d want 1/127", done_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int busy, done_at, errs;
    logic [31:0] exp_a [5];
    exp_a[0] = 32'hFFFF_FFF0; exp_a[1] = 32'hFFFF_FFF4; exp_a[2] = 32'hFFFF_FFF8;
    exp_a[3] = 32'hFFFF_FFFC; exp_a[4] = 32'h0000_0000;
    preload_save(); clear_mon(); wait_w = 1;
    start(1, 0, 32'hFFFF_FFF0);
    run_seq(0, 0, -1, busy, done_at);
    errs = 0;
    for (int i = 0; i < 5; i++) if (wr_addr.size() <= i || wr_addr[i] !== exp_a[i]) errs++;
    total_cnt++;
    if (errs != 0) $display("FAIL wrap_addr: %0d errs, a[3]=%h a[4]=%h want fffffffc/00000000", errs, wr_addr[3], wr_addr[4]);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr.size() != 63 || wr_addr[62] !== 32'h0000_00E8) $display("FAIL wrap_last: n=%0d last=%h want 63/000000e8", wr_addr.size(), wr_addr[62]);
    else pass_cnt++;
    total_cnt++;
    if (busy != 190 || stab_err != 0) $display("FAIL wrap_wait1: busy=%0d unstable=%0d want 190/0", busy, stab_err);
    else pass_cnt++;
  endtask

  initial begin
    bus.Save_Req = 1'b0; bus.Restore_Req = 1'b0; bus.Abort = 1'b0; bus.Base_Addr = '0;
    clear_mon();
    for (int k = 0; k < 64; k++) rf[k] = '0;
    #1;
    test_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_save();
    test_restore();
    test_both_req();
    test_abort();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reg_ctx_sequencer.md
# reg_ctx_sequencer

Context save/restore sequencer for the 64×32 register file. On request it walks registers FIRST_REG..LAST_REG through the register file's third port (select/write/read-back) and moves each word to or from a memory buffer at a caller-supplied base address. It sits between the core's trap/interrupt logic, the register file and the data-memory port. It holds the register file for the whole sequence.

## Interface
Parameters:
- FIRST_REG, 1: first register moved; register 0 is never saved or restored.
- LAST_REG, 63: last register moved; FIRST_REG ≤ LAST_REG ≤ 63.
- ADDR_STRIDE, 4: byte offset between consecutive buffer words.

Ports:
- Slow_Clock  in  1  single clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Save_Req  in  1  start save; sampled in IDLE only.
- Restore_Req  in  1  start restore; sampled in IDLE only.
- Abort  in  1  terminate the running sequence.
- Base_Addr  in  32  buffer base; latched at start.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on normal completion.
- Aborted  out  1  one-cycle pulse on abort completion.
- Rf_Sel  out  6  register-file port-3 select (Reg_WR).
- Rf_Write  out  1  register-file write enable.
- Rf_Write_Data  out  32  register-file write data.
- Rf_Read_Data  in  32  register-file port-3 read data (Data_3).
- Mem_Req, Mem_Write  out  1 each  memory request; 1 = write.
- Mem_Addr, Mem_Wdata  out  32 each  memory address and write data.
- Mem_Ack  in  1  transaction complete at this posedge.
- Mem_Rdata  in  32  read data, valid with Mem_Ack.

## Operation
- States: IDLE, SAVE_RD, SAVE_MEM, RST_MEM, RST_WR, FINISH.
- IDLE:
  - Save_Req → latch Base_Addr, idx=FIRST_REG, go to SAVE_RD.
  - Else Restore_Req → same latch, go to RST_MEM.
  - Both high at once: save wins; restore is dropped.
  - Requests outside IDLE are ignored, not queued.
- SAVE_RD: Rf_Sel=idx; capture Rf_Read_Data into a data register; go to SAVE_MEM.
- SAVE_MEM: Mem_Req=1, Mem_Write=1, Mem_Wdata=captured word. Hold until Mem_Ack.
  - On Ack: if idx==LAST_REG go to FINISH; else idx+1 and go to SAVE_RD.
- RST_MEM: Mem_Req=1, Mem_Write=0. Hold until Mem_Ack; on Ack capture Mem_Rdata and go to RST_WR.
- RST_WR: Rf_Sel=idx, Rf_Write=1, Rf_Write_Data=captured word. The register file commits the write on the negedge inside this cycle.
  - Then: if idx==LAST_REG go to FINISH; else idx+1 and go to RST_MEM.
- FINISH: pulse Done (or Aborted, if the sequence was aborted); go to IDLE.
- Address: Mem_Addr = latched base + (idx−FIRST_REG)·ADDR_STRIDE, computed modulo 2^32 (wraps silently).
- Abort:
  - Sampled every busy cycle and set as sticky.
  - If Mem_Req is high, the current transaction completes on Ack first; no new Rf_Write is issued after the abort is taken.
  - Next state is FINISH, with Aborted pulsed and Done not pulsed.
- Mem_Req, Mem_Write, Mem_Addr and Mem_Wdata stay constant from request assertion through the Ack cycle.
- Rf_Write is high only in RST_WR, and Rf_Sel is never 0 while Rf_Write is high.

## Timing
- Reset: every output is 0, state=IDLE, idx=FIRST_REG. Reset asserted mid-sequence aborts immediately with no Done/Aborted pulse; the memory transaction is abandoned.
- Start: request sampled at posedge N → Busy=1 from cycle N+1.
- Mem_Ack may be high in the first Mem_Req cycle, which gives a zero-wait transaction.
- Per register with W wait cycles:
  - Save: 2+W cycles.
  - Restore: 2+W cycles.
- Full 63-register sequence at zero wait: 126 cycles, plus 1 FINISH cycle. Busy stays high 127 cycles; Done is in the 127th.
- Mem_Ack outside Mem_Req is ignored.

## Test plan
- Save, zero wait: preload reg k=k·0x01010101, Base_Addr=0x1000 → 63 writes to 0x1000..0x10F8 with matching data; Done in cycle 127; Rf_Write never 1.
- Restore, 2 wait cycles per Ack: memory word i=0xA5000000+i → reg k=0xA5000000+(k−1); reg 0 unchanged; Done after 63·4+1=253 busy cycles.
- Save_Req and Restore_Req in the same cycle → save sequence runs. Restore_Req pulsed while busy → no effect.
- Abort raised during restore of reg 10 while waiting in RST_MEM → Ack completes the transaction; reg 10 is not written; Aborted pulses; Done stays 0.
- Reset_n low mid-save (idx=30) → all outputs 0 at once; after release, Save_Req restarts at idx=1 and Base_Addr is re-latched.
- Base_Addr=0xFFFFFFF0 → addresses 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, … (wrap).
